hilo_muldiv_controller: RTL and testbench

HILO_MULDIV_CONTROLLER -- requirements
Module: hilo_muldiv_controller

---
 rtl/hilo_muldiv_controller.sv | 166 ++++++++++++++++
 tb/tb_hilo_muldiv_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_controller.sv
// HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide
// with a final sign-fix cycle, plus MTHI/MTLO writes and a pipeline stall output.
module hilo_muldiv_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [4:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            hilo_read,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MTLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mag_q, mag_d;
  logic              neg_q, neg_d, rneg_q, rneg_d, is_div_q, is_div_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d, dz_q, dz_d;

  // bit 0 of the op code is the "unsigned" flag for MULT/MULTU and DIV/DIVU
  logic            sgn, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  assign sgn   = ~alu_control[0];
  assign a_neg = sgn & op_a[XLEN-1];
  assign b_neg = sgn & op_b[XLEN-1];
  assign abs_a = a_neg ? -op_a : op_a;
  assign abs_b = b_neg ? -op_b : op_b;

  // multiply step: {hi_acc, multiplier} shifts right, multiplicand added into the top
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : {(XLEN+1){1'b0}});
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

  // restoring divide step: {rem, quo} shifts left, trial-subtract the divisor
  logic [2*XLEN:0]   div_sh;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_nxt;
  assign div_sh    = {acc_q, 1'b0};
  assign div_trial = div_sh[2*XLEN:XLEN] - {1'b0, mag_q};
  assign div_nxt   = div_trial[XLEN] ? div_sh[2*XLEN-1:0]
                                     : {div_trial[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (alu_control)
            OP_MULT, OP_MULTU: begin
              mag_d    = abs_a;
              acc_d    = {{XLEN{1'b0}}, abs_b};
              neg_d    = a_neg ^ b_neg;
              rneg_d   = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (op_b == '0) begin
                done_d = 1'b1;
                dz_d   = 1'b1;
              end else begin
                mag_d    = abs_b;
                acc_d    = {{XLEN{1'b0}}, abs_a};
                neg_d    = a_neg ^ b_neg;
                rneg_d   = a_neg;
                is_div_d = 1'b1;
                cnt_d    = '0;
                state_d  = S_DIV;
              end
            end
            OP_MTLO: lo_d = op_a;
            OP_MTHI: hi_d = op_a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_q  ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
          hi_d = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        end else begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign stall    = busy & (hilo_read | start);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_controller.sv
// Scoreboard bench for hilo_muldiv_controller: expected HI/LO/div_zero queued at
// issue, popped and compared on each done pulse.
module tb_hilo_muldiv_controller;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MTLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;

  logic        clk = 1'b0;
  logic        reset_n, start, hilo_read;
  logic [4:0]  alu_control;
  logic [31:0] op_a, op_b;
  logic        busy, stall, done, div_zero;
  logic [31:0] hi, lo;

  hilo_muldiv_controller #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .alu_control(alu_control),
    .op_a(op_a), .op_b(op_b), .hilo_read(hilo_read), .busy(busy), .stall(stall),
    .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // reference model: updates the model HI/LO and returns the expected completion
  task automatic predict(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.dz = 1'b0;
    case (op)
      OP_MULT:  begin p = longint'(sa * sb); {m_hi, m_lo} = p; end
      OP_MULTU: begin p = ua * ub;           {m_hi, m_lo} = p; end
      OP_DIV, OP_DIVU: begin
        if (b == 0) e.dz = 1'b1;
        else if (op == OP_DIV) begin
          q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = 32'(ua / ub); m_hi = 32'(ua % ub);
        end
      end
      default: ;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
  endtask

  // scoreboard side: compare on every completion pulse
  logic done_d1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) done_d1 = 1'b0;
    else begin
      if (done) begin
        chk("done_width", {63'b0, done_d1}, 64'd0);
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: got done with empty queue exp none");
        end else begin
          e = sb_q.pop_front();
          chk("res_hi", {32'b0, hi}, {32'b0, e.hi});
          chk("res_lo", {32'b0, lo}, {32'b0, e.lo});
          chk("res_dz", {63'b0, div_zero}, {63'b0, e.dz});
        end
      end
      if (div_zero) chk("dz_qual", {63'b0, done}, 64'd1);
      done_d1 = done;
    end
  end

  // issue one op and wait for its done; b2b drives start in the current (done) cycle
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b, input bit poke);
    exp_t        e;
    logic [31:0] prev_hi, prev_lo;
    int          nb, cyc, exp_busy;
    if (!b2b) @(negedge clk);
    prev_hi = m_hi;
    prev_lo = m_lo;
    predict(op, a, b, e);
    exp_busy = e.dz ? 0 : 33;
    alu_control = op; op_a = a; op_b = b; start = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    nb = 0; cyc = 0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      if (cyc == 16) begin
        chk("hold_hi", {32'b0, hi}, {32'b0, prev_hi});
        chk("hold_lo", {32'b0, lo}, {32'b0, prev_lo});
      end
      if (poke && cyc == 5) begin
        hilo_read = 1'b1;
        #1 chk("stall_read", {63'b0, stall}, 64'd1);
        hilo_read = 1'b0;
        alu_control = OP_MTLO; op_a = 32'hDEADBEEF; start = 1'b1;
        #1 chk("stall_start", {63'b0, stall}, 64'd1);
      end
      if (poke && cyc == 6) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", {63'b0, done}, 64'd1);
    chk("busy_cycles", 64'(nb), 64'(exp_busy));
  endtask

  initial begin
    logic [4:0] ops [4];
    ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
    reset_n = 1'b0; start = 1'b0; hilo_read = 1'b0;
    alu_control = '0; op_a = '0; op_b = '0;
    #3;
    chk("rst_hi",   {32'b0, hi}, 64'd0);
    chk("rst_lo",   {32'b0, lo}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_dz",   {63'b0, div_zero}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    hilo_read = 1'b1;
    #1 chk("stall_idle", {63'b0, stall}, 64'd0);
    hilo_read = 1'b0;

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    chk("multu_max", {32'b0, hi, lo} >> 0, {32'hFFFFFFFE, 32'h00000001});
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 1'b0, 1'b0);
    chk("mult_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b0);
    chk("div_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("div_ovf", {hi, lo}, {32'h00000000, 32'h80000000});
    run_op(OP_DIVU, 32'h00000064, 32'h00000000, 1'b0, 1'b0);
    chk("divz_keep", {hi, lo}, {32'h00000000, 32'h80000000});

    @(negedge clk);
    alu_control = OP_MTHI; op_a = 32'h12345678; start = 1'b1;
    @(negedge clk);
    start = 1'b0; m_hi = 32'h12345678;
    chk("mthi_hi",   {32'b0, hi}, {32'b0, m_hi});
    chk("mthi_busy", {63'b0, busy}, 64'd0);
    chk("mthi_done", {63'b0, done}, 64'd0);
    alu_control = OP_MTLO; op_a = 32'hCAFEF00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0; m_lo = 32'hCAFEF00D;
    chk("mtlo_lo", {32'b0, lo}, {32'b0, m_lo});
    alu_control = 5'b00111; op_a = 32'h1; op_b = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bad_op_busy", {63'b0, busy}, 64'd0);
    chk("bad_op_hilo", {hi, lo}, {m_hi, m_lo});

    for (int i = 0; i < 6; i++)
      run_op(ops[$urandom_range(0, 3)], $urandom, (i == 3) ? 32'h0 : $urandom, 1'b0, 1'b0);

    @(negedge clk);
    alu_control = OP_DIV; op_a = 32'h7FFF1234; op_b = 32'h00000013; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_done", {63'b0, done}, 64'd0);
    m_hi = '0; m_lo = '0;
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    run_op(OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b0);
    chk("post_rst_mul", {hi, lo}, {32'h0, 32'h0000000F});

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
